eth_demux: RTL and testbench

- Ethernet frame demultiplexer: one input frame stream (header plus AXI-Stream payload) is routed to one of M_COUNT output ports.
- It is the fan-out counterpart of the arbitrated Ethernet mux. It sits between the common RX Ethernet path and per-protocol consumers (RoCE/UDP stack vs. generic IP/ARP).
- The route for each frame is chosen by `select` and `drop`, sampled once per frame when the header is accepted, and held until that frame's tlast.

---
 rtl/eth_demux.sv | 201 ++++++++++++++++++++
 tb/tb_eth_demux.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_demux.sv
// Ethernet frame demultiplexer: steers one header + AXI-Stream payload stream to one of
// M_COUNT ports. Route (select/drop) is captured per frame when the header is accepted.
module eth_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int CL_M_COUNT  = $clog2(M_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_eth_hdr_valid,
  output logic                          s_eth_hdr_ready,
  input  logic [47:0]                   s_eth_dest_mac,
  input  logic [47:0]                   s_eth_src_mac,
  input  logic [15:0]                   s_eth_type,
  input  logic                          s_is_roce_packet,
  input  logic [DATA_WIDTH-1:0]         s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_eth_payload_axis_tkeep,
  input  logic                          s_eth_payload_axis_tvalid,
  output logic                          s_eth_payload_axis_tready,
  input  logic                          s_eth_payload_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_eth_payload_axis_tuser,
  output logic [M_COUNT-1:0]            m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]            m_eth_hdr_ready,
  output logic [M_COUNT*48-1:0]         m_eth_dest_mac,
  output logic [M_COUNT*48-1:0]         m_eth_src_mac,
  output logic [M_COUNT*16-1:0]         m_eth_type,
  output logic [M_COUNT-1:0]            m_is_roce_packet,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic [M_COUNT-1:0]            m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_eth_payload_axis_tready,
  output logic [M_COUNT-1:0]            m_eth_payload_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0] m_eth_payload_axis_tuser,
  input  logic                          enable,
  input  logic                          drop,
  input  logic [CL_M_COUNT-1:0]         select
);

  logic                  frame_reg;
  logic                  drop_reg;
  logic [CL_M_COUNT-1:0] select_reg;
  logic [M_COUNT-1:0]    hdr_valid_reg;
  logic [M_COUNT-1:0]    hdr_valid_next;
  logic [47:0]           dest_mac_reg;
  logic [47:0]           src_mac_reg;
  logic [15:0]           type_reg;
  logic                  roce_reg;

  logic [M_COUNT-1:0]    out_valid_reg;
  logic [M_COUNT-1:0]    out_valid_next;
  logic [M_COUNT-1:0]    temp_valid_reg;
  logic [M_COUNT-1:0]    temp_valid_next;
  logic [M_COUNT-1:0]    valid_int;
  logic                  out_ready_int_reg;
  logic                  out_ready_early;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [DATA_WIDTH-1:0] temp_data_reg;
  logic [KEEP_WIDTH-1:0] out_keep_reg;
  logic [KEEP_WIDTH-1:0] temp_keep_reg;
  logic                  out_last_reg;
  logic                  temp_last_reg;
  logic [USER_WIDTH-1:0] out_user_reg;
  logic [USER_WIDTH-1:0] temp_user_reg;
  logic                  store_int_to_out;
  logic                  store_int_to_temp;
  logic                  store_temp_to_out;

  logic                  sel_oob;
  logic                  sel_free;
  logic                  drop_eff;
  logic                  hdr_xfer;
  logic                  beat_xfer;
  logic [M_COUNT-1:0]    sel_onehot;
  logic [M_COUNT-1:0]    sel_reg_onehot;
  logic                  out_drain;

  // Decode the live select (header acceptance) and the latched select (payload steering)
  always_comb begin
    sel_onehot     = '0;
    sel_reg_onehot = '0;
    sel_free       = 1'b0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (select == CL_M_COUNT'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_free      = !hdr_valid_reg[i] || m_eth_hdr_ready[i];
      end
      if (select_reg == CL_M_COUNT'(i)) begin
        sel_reg_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_oob  = (32'(select) >= M_COUNT);
  assign drop_eff = drop || sel_oob;

  assign s_eth_hdr_ready           = !rst && !frame_reg && enable && (drop_eff || sel_free);
  assign s_eth_payload_axis_tready = frame_reg && (drop_reg || out_ready_int_reg);

  assign hdr_xfer  = s_eth_hdr_valid && s_eth_hdr_ready;
  assign beat_xfer = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign valid_int = (beat_xfer && !drop_reg) ? sel_reg_onehot : '0;

  assign hdr_valid_next = (hdr_valid_reg & ~m_eth_hdr_ready) |
                          ((hdr_xfer && !drop_eff) ? sel_onehot : '0);

  // Skid buffer steering; valids are one-hot vectors so a select change for the next
  // frame cannot strand a beat still waiting in the output register.
  assign out_drain = |(m_eth_payload_axis_tready & out_valid_reg);

  always_comb begin
    out_valid_next    = out_valid_reg;
    temp_valid_next   = temp_valid_reg;
    store_int_to_out  = 1'b0;
    store_int_to_temp = 1'b0;
    store_temp_to_out = 1'b0;
    if (out_ready_int_reg) begin
      if (out_drain || !(|out_valid_reg)) begin
        out_valid_next   = valid_int;
        store_int_to_out = 1'b1;
      end else begin
        temp_valid_next   = valid_int;
        store_int_to_temp = 1'b1;
      end
    end else if (out_drain) begin
      out_valid_next    = temp_valid_reg;
      temp_valid_next   = '0;
      store_temp_to_out = 1'b1;
    end
  end

  assign out_ready_early = out_drain ||
                           (!(|temp_valid_reg) && (!(|out_valid_reg) || !(|valid_int)));

  // Control state: the only registers touched by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg         <= 1'b0;
      drop_reg          <= 1'b0;
      select_reg        <= '0;
      hdr_valid_reg     <= '0;
      out_valid_reg     <= '0;
      temp_valid_reg    <= '0;
      out_ready_int_reg <= 1'b0;
    end else begin
      if (hdr_xfer) begin
        frame_reg  <= 1'b1;
        select_reg <= select;
        drop_reg   <= drop_eff;
      end else if (beat_xfer && s_eth_payload_axis_tlast) begin
        frame_reg <= 1'b0;
      end
      hdr_valid_reg     <= hdr_valid_next;
      out_valid_reg     <= out_valid_next;
      temp_valid_reg    <= temp_valid_next;
      out_ready_int_reg <= out_ready_early;
    end
  end

  // Header fields and payload datapath
  always_ff @(posedge clk) begin
    if (hdr_xfer) begin
      dest_mac_reg <= s_eth_dest_mac;
      src_mac_reg  <= s_eth_src_mac;
      type_reg     <= s_eth_type;
      roce_reg     <= s_is_roce_packet;
    end
    if (store_int_to_out) begin
      out_data_reg <= s_eth_payload_axis_tdata;
      out_keep_reg <= s_eth_payload_axis_tkeep;
      out_last_reg <= s_eth_payload_axis_tlast;
      out_user_reg <= s_eth_payload_axis_tuser;
    end else if (store_temp_to_out) begin
      out_data_reg <= temp_data_reg;
      out_keep_reg <= temp_keep_reg;
      out_last_reg <= temp_last_reg;
      out_user_reg <= temp_user_reg;
    end
    if (store_int_to_temp) begin
      temp_data_reg <= s_eth_payload_axis_tdata;
      temp_keep_reg <= s_eth_payload_axis_tkeep;
      temp_last_reg <= s_eth_payload_axis_tlast;
      temp_user_reg <= s_eth_payload_axis_tuser;
    end
  end

  assign m_eth_hdr_valid           = hdr_valid_reg;
  assign m_eth_dest_mac            = {M_COUNT{dest_mac_reg}};
  assign m_eth_src_mac             = {M_COUNT{src_mac_reg}};
  assign m_eth_type                = {M_COUNT{type_reg}};
  assign m_is_roce_packet          = {M_COUNT{roce_reg}};
  assign m_eth_payload_axis_tdata  = {M_COUNT{out_data_reg}};
  assign m_eth_payload_axis_tkeep  = KEEP_ENABLE ? {M_COUNT{out_keep_reg}} : '1;
  assign m_eth_payload_axis_tvalid = out_valid_reg;
  assign m_eth_payload_axis_tlast  = {M_COUNT{out_last_reg}};
  assign m_eth_payload_axis_tuser  = USER_ENABLE ? {M_COUNT{out_user_reg}} : '0;

endmodule

// File: tb/tb_eth_demux.sv
// Directed bench for eth_demux: routing, drop, back-pressure, frame spacing, enable gating
// and mid-frame reset, with per-port beat capture compared against hand-built frames.
module tb_eth_demux;

  typedef struct packed {
    logic [2:0]  port;
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_hdr_valid;
  logic         s_hdr_ready;
  logic [47:0]  s_dest, s_src;
  logic [15:0]  s_type;
  logic         s_roce;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tvalid, s_tready, s_tlast;
  logic [0:0]   s_tuser;
  logic [3:0]   m_hdr_valid, m_hdr_ready;
  logic [191:0] m_dest, m_src;
  logic [63:0]  m_type;
  logic [3:0]   m_roce;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [3:0]   m_tvalid, m_tready, m_tlast, m_tuser;
  logic         enable, drop;
  logic [2:0]   sel;

  eth_demux #(.M_COUNT(4), .DATA_WIDTH(64), .CL_M_COUNT(3)) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_is_roce_packet(s_roce),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_is_roce_packet(m_roce),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .enable(enable), .drop(drop), .select(sel)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_bad = 0;
  int    cyc = 0;
  beat_t rxq[$];
  int    hdr_cnt[4];
  int    hdr_type = 0;
  int    in_beats = 0;
  int    tlast_cyc = 0;
  int    hdr_cyc = 0;
  int    stall_run = 0;
  int    stall_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture everything that would be handshaken at the following rising edge
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          b.port = 3'(i);
          b.last = m_tlast[i];
          b.keep = m_tkeep[i*8 +: 8];
          b.data = m_tdata[i*64 +: 64];
          rxq.push_back(b);
        end
        if (m_hdr_valid[i]) begin
          hdr_cnt[i] = hdr_cnt[i] + 1;
          if (m_hdr_ready[i]) hdr_type = int'(m_type[i*16 +: 16]);
        end
      end
      if (s_tvalid && s_tready) begin
        in_beats = in_beats + 1;
        if (s_tlast) tlast_cyc = cyc;
      end
      if (s_hdr_valid && s_hdr_ready) hdr_cyc = cyc;
      if (m_tvalid[1] && !m_tready[1] && s_tvalid && s_tready) stall_run = stall_run + 1;
      else stall_run = 0;
      if (stall_run > stall_max) stall_max = stall_run;
    end
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_hdr(input logic [2:0] s, input logic d, input logic [15:0] t);
    int w;
    s_hdr_valid = 1'b1;
    sel  = s;
    drop = d;
    s_type = t;
    s_dest = 48'h0200_0000_00AA;
    s_src  = 48'h0200_0000_00BB;
    w = 0;
    @(negedge clk);
    while (!s_hdr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("hdr_timeout", 96'(w), 96'd0);
    @(posedge clk);
    #1;
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [63:0] base, input int last_at);
    int w;
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(b);
      s_tlast  = (b == last_at);
      s_tkeep  = (b == last_at) ? 8'h0F : 8'hFF;
      s_tuser  = 1'b0;
      w = 0;
      @(negedge clk);
      while (!s_tready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk("beat_timeout", 96'(w), 96'd0);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int idx, input int port, input int n,
                             input logic [63:0] base);
    logic [95:0] got, exp;
    for (int b = 0; b < n; b++) begin
      if (idx + b < rxq.size())
        got = {20'd0, rxq[idx+b].port, rxq[idx+b].last, rxq[idx+b].keep, rxq[idx+b].data};
      else
        got = '1;
      exp = {20'd0, 3'(port), (b == n - 1), ((b == n - 1) ? 8'h0F : 8'hFF), base + 64'(b)};
      chk(tag, got, exp);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, h0[4], ib0, ready_seen;
    rst = 1'b1;
    s_hdr_valid = 1'b0; s_dest = '0; s_src = '0; s_type = '0; s_roce = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    m_hdr_ready = 4'hF; m_tready = 4'hF;
    enable = 1'b1; drop = 1'b0; sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 96'({m_hdr_valid, m_tvalid, s_hdr_ready, s_tready}), 96'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Frame routed to port 2
    idx = rxq.size(); h0 = hdr_cnt;
    send_hdr(3'd2, 1'b0, 16'h8915);
    send_payload(8, 64'h0000_0000_0000_1000, 7);
    drain();
    for (int i = 0; i < 4; i++)
      chk("t1_hdr_cycles", 96'(hdr_cnt[i] - h0[i]), (i == 2) ? 96'd1 : 96'd0);
    chk("t1_hdr_type", 96'(hdr_type), 96'h8915);
    chk("t1_beat_count", 96'(rxq.size() - idx), 96'd8);
    check_frame("t1_beat", idx, 2, 8, 64'h0000_0000_0000_1000);

    // Dropped frames: explicit drop, then out-of-range select
    for (int k = 0; k < 2; k++) begin
      idx = rxq.size(); h0 = hdr_cnt; ib0 = in_beats;
      if (k == 0) send_hdr(3'd1, 1'b1, 16'h0800);
      else        send_hdr(3'd7, 1'b0, 16'h0806);
      drop = 1'b0;
      send_payload(5, 64'h0000_0000_0000_2000, 4);
      drain();
      chk("t2_in_beats", 96'(in_beats - ib0), 96'd5);
      chk("t2_out_beats", 96'(rxq.size() - idx), 96'd0);
      chk("t2_hdr_cycles", 96'((hdr_cnt[0] - h0[0]) + (hdr_cnt[1] - h0[1]) +
                               (hdr_cnt[2] - h0[2]) + (hdr_cnt[3] - h0[3])), 96'd0);
    end

    // Back-pressure on port 1
    idx = rxq.size(); stall_max = 0;
    send_hdr(3'd1, 1'b0, 16'h0800);
    fork
      send_payload(6, 64'h0000_0000_0000_3000, 5);
      begin
        logic [5:0] pat;
        pat = 6'b101001;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk);
          #1;
          m_tready[1] = pat[k];
        end
        @(posedge clk);
        #1;
        m_tready[1] = 1'b1;
      end
    join
    m_tready[1] = 1'b1;
    drain();
    chk("t3_beat_count", 96'(rxq.size() - idx), 96'd6);
    check_frame("t3_beat", idx, 1, 6, 64'h0000_0000_0000_3000);
    chk("t3_stall_accepts", 96'(stall_max), 96'd1);

    // Back-to-back frames, select changed mid-frame 1
    idx = rxq.size();
    send_hdr(3'd0, 1'b0, 16'h0800);
    sel = 3'd3;
    send_payload(4, 64'h0000_0000_0000_4000, 3);
    send_hdr(3'd3, 1'b0, 16'h8915);
    chk("t4_hdr_gap", 96'(hdr_cyc - tlast_cyc), 96'd1);
    send_payload(3, 64'h0000_0000_0000_5000, 2);
    drain();
    chk("t4_beat_count", 96'(rxq.size() - idx), 96'd7);
    check_frame("t4_frame1", idx, 0, 4, 64'h0000_0000_0000_4000);
    check_frame("t4_frame2", idx + 4, 3, 3, 64'h0000_0000_0000_5000);

    // Enable gating of header acceptance
    idx = rxq.size();
    enable = 1'b0; s_hdr_valid = 1'b1; sel = 3'd0; drop = 1'b0; s_type = 16'h0806;
    ready_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_hdr_ready) ready_seen++;
    end
    chk("t5_ready_disabled", 96'(ready_seen), 96'd0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    chk("t5_ready_enabled", 96'(s_hdr_ready), 96'd1);
    @(posedge clk);
    #1;
    s_hdr_valid = 1'b0;
    send_payload(2, 64'h0000_0000_0000_6000, 1);
    drain();
    check_frame("t5_beat", idx, 0, 2, 64'h0000_0000_0000_6000);

    // Reset in the middle of a frame
    send_hdr(3'd1, 1'b0, 16'h0800);
    send_payload(3, 64'h0000_0000_0000_7000, 99);
    chk("t6_pre_reset_valid", 96'(m_tvalid), 96'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_clear", 96'({m_hdr_valid, m_tvalid, s_tready, s_hdr_ready}), 96'd0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    idx = rxq.size(); h0 = hdr_cnt;
    send_hdr(3'd2, 1'b0, 16'h88B5);
    send_payload(4, 64'h0000_0000_0000_8000, 3);
    drain();
    chk("t6_hdr_port2", 96'(hdr_cnt[2] - h0[2]), 96'd1);
    chk("t6_beat_count", 96'(rxq.size() - idx), 96'd4);
    check_frame("t6_beat", idx, 2, 4, 64'h0000_0000_0000_8000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
